// File: rtl/ibex_mem_mux_pkg.sv
// Shared types and defaults for the Ibex memory-bus multiplexer.
// The integrity pass-through is selected with IBEX_MEM_MUX_INTG_EN.
package ibex_mem_mux_pkg;

   localparam int unsigned DEFAULT_NUM_HOSTS       = 2;
   localparam int unsigned DEFAULT_ADDR_WIDTH      = 32;
   localparam int unsigned DEFAULT_DATA_WIDTH      = 32;
   localparam int unsigned DEFAULT_INTG_WIDTH      = 7;
   localparam int unsigned DEFAULT_MAX_OUTSTANDING = 4;

   // A host index needs at least one bit even when only one host exists.
   function automatic int unsigned idx_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   typedef logic [idx_width(DEFAULT_NUM_HOSTS)-1:0] host_idx_t;

   typedef struct packed {
      logic [DEFAULT_ADDR_WIDTH-1:0]   addr;
      logic                            we;
      logic [DEFAULT_DATA_WIDTH/8-1:0] be;
      logic [DEFAULT_DATA_WIDTH-1:0]   wdata;
      logic [DEFAULT_INTG_WIDTH-1:0]   wintg;
   } req_payload_t;

endpackage

// File: rtl/ibex_mem_mux_id_fifo.sv
// Synchronous FIFO holding the issuing host index of each outstanding request.
// Pointers wrap modulo DEPTH; occupancy is kept in a separate counter.
module ibex_mem_mux_id_fifo #(
   parameter int unsigned WIDTH = 1,
   parameter int unsigned DEPTH = 4,
   localparam int unsigned CNT_W = $clog2(DEPTH + 1),
   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push_i,
   input  logic [WIDTH-1:0] data_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] data_o,
   output logic             full_o,
   output logic             empty_o,
   output logic [CNT_W-1:0] count_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             push_ok, pop_ok;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign full_o  = (count_q == CNT_W'(DEPTH));
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign data_o  = mem_q[rd_ptr_q];
   assign push_ok = push_i & ~full_o;
   assign pop_ok  = pop_i & ~empty_o;

   always_comb begin
      // NOTE: defaults come first so every path assigns every output and no latch is inferred.
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
      if (push_ok) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop_ok)  rd_ptr_d = ptr_inc(rd_ptr_q);
   end

   always_ff @(posedge clk or posedge reset) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // NOTE: storage is not reset; only entries between the reset pointers are ever read.
   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_ptr_q] <= data_i;
   end

endmodule

// File: rtl/ibex_mem_mux.sv
// N-host to one-device Ibex memory-bus mux: round-robin with request lock, in-order
// response routing. Define IBEX_MEM_MUX_INTG_EN to pass wintg/rintg through.
module ibex_mem_mux
   import ibex_mem_mux_pkg::*;
#(
   parameter int unsigned NUM_HOSTS       = DEFAULT_NUM_HOSTS,
   parameter int unsigned ADDR_WIDTH      = DEFAULT_ADDR_WIDTH,
   parameter int unsigned DATA_WIDTH      = DEFAULT_DATA_WIDTH,
   parameter int unsigned INTG_WIDTH      = DEFAULT_INTG_WIDTH,
   parameter int unsigned MAX_OUTSTANDING = DEFAULT_MAX_OUTSTANDING,
   localparam int unsigned OUT_W          = $clog2(MAX_OUTSTANDING + 1)
) (
   input  logic                                   clk,
   input  logic                                   reset,
   input  logic [NUM_HOSTS-1:0]                   host_req_i,
   output logic [NUM_HOSTS-1:0]                   host_gnt_o,
   input  logic [NUM_HOSTS-1:0][ADDR_WIDTH-1:0]   host_addr_i,
   input  logic [NUM_HOSTS-1:0]                   host_we_i,
   input  logic [NUM_HOSTS-1:0][DATA_WIDTH/8-1:0] host_be_i,
   input  logic [NUM_HOSTS-1:0][DATA_WIDTH-1:0]   host_wdata_i,
   input  logic [NUM_HOSTS-1:0][INTG_WIDTH-1:0]   host_wintg_i,
   output logic [NUM_HOSTS-1:0]                   host_rvalid_o,
   output logic [DATA_WIDTH-1:0]                  host_rdata_o,
   output logic [INTG_WIDTH-1:0]                  host_rintg_o,
   output logic [NUM_HOSTS-1:0]                   host_err_o,
   output logic                                   dev_req_o,
   output logic [ADDR_WIDTH-1:0]                  dev_addr_o,
   output logic                                   dev_we_o,
   output logic [DATA_WIDTH/8-1:0]                dev_be_o,
   output logic [DATA_WIDTH-1:0]                  dev_wdata_o,
   output logic [INTG_WIDTH-1:0]                  dev_wintg_o,
   input  logic                                   dev_gnt_i,
   input  logic                                   dev_rvalid_i,
   input  logic [DATA_WIDTH-1:0]                  dev_rdata_i,
   input  logic [INTG_WIDTH-1:0]                  dev_rintg_i,
   input  logic                                   dev_err_i,
   output logic [OUT_W-1:0]                       outstanding_o,
   output logic                                   unexp_rvalid_o
);

   localparam int unsigned IDX_W = idx_width(NUM_HOSTS);

   logic [NUM_HOSTS-1:0] req_eff;
   logic [IDX_W-1:0]     winner, head;
   logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d, lock_idx_q, lock_idx_d;
   logic                 lock_q, lock_d, unexp_q, unexp_d;
   logic                 found, handshake, rvalid_eff, pop, fifo_full, fifo_empty;
   int unsigned          cand;

   // Masking during reset forces every combinational output to zero.
   assign req_eff    = host_req_i & {NUM_HOSTS{~reset}};
   assign rvalid_eff = dev_rvalid_i & ~reset;

   always_comb begin
      winner = '0;
      found  = 1'b0;
      cand   = 0;
      if (lock_q && req_eff[lock_idx_q]) begin
         winner = lock_idx_q;
         found  = 1'b1;
      end else begin
         for (int unsigned k = 0; k < NUM_HOSTS; k++) begin
            cand = (32'(rr_ptr_q) + k) % NUM_HOSTS;
            if (!found && req_eff[cand]) begin
               winner = IDX_W'(cand);
               found  = 1'b1;
            end
         end
      end
   end

   assign dev_req_o  = (|req_eff) & ~fifo_full;
   assign handshake  = dev_req_o & dev_gnt_i;
   assign host_gnt_o = handshake ? (NUM_HOSTS'(1) << winner) : '0;

   always_comb begin
      dev_addr_o  = '0;
      dev_we_o    = 1'b0;
      dev_be_o    = '0;
      dev_wdata_o = '0;
      dev_wintg_o = '0;
      if (dev_req_o) begin
         dev_addr_o  = host_addr_i[winner];
         dev_we_o    = host_we_i[winner];
         dev_be_o    = host_be_i[winner];
         dev_wdata_o = host_wdata_i[winner];
`ifdef IBEX_MEM_MUX_INTG_EN
         dev_wintg_o = host_wintg_i[winner];
`endif
      end
   end

`ifdef IBEX_MEM_MUX_INTG_EN
   assign host_rintg_o = reset ? '0 : dev_rintg_i;
`else
   logic unused_intg;
   assign unused_intg  = ^{host_wintg_i, dev_rintg_i};
   assign host_rintg_o = '0;
`endif

   // A response with nothing outstanding is dropped and only raises the sticky flag.
   assign pop           = rvalid_eff & ~fifo_empty;
   assign host_rvalid_o = pop ? (NUM_HOSTS'(1) << head) : '0;
   assign host_err_o    = host_rvalid_o & {NUM_HOSTS{dev_err_i}};
   assign host_rdata_o  = reset ? '0 : dev_rdata_i;
   assign unexp_rvalid_o = unexp_q;

   always_comb begin
      rr_ptr_d   = rr_ptr_q;
      lock_d     = 1'b0;
      lock_idx_d = lock_idx_q;
      unexp_d    = unexp_q | (rvalid_eff & fifo_empty);
      if (handshake) begin
         rr_ptr_d = IDX_W'((32'(winner) + 1) % NUM_HOSTS);
      end else if (dev_req_o) begin
         lock_d     = 1'b1;
         lock_idx_d = winner;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rr_ptr_q   <= '0;
         lock_q     <= 1'b0;
         lock_idx_q <= '0;
         unexp_q    <= 1'b0;
      end else begin
         rr_ptr_q   <= rr_ptr_d;
         lock_q     <= lock_d;
         lock_idx_q <= lock_idx_d;
         unexp_q    <= unexp_d;
      end
   end

   ibex_mem_mux_id_fifo #(
      .WIDTH (IDX_W),
      .DEPTH (MAX_OUTSTANDING)
   ) u_id_fifo (
      .clk     (clk),
      .reset   (reset),
      .push_i  (handshake),
      .data_i  (winner),
      .pop_i   (pop),
      .data_o  (head),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (outstanding_o)
   );

endmodule
